servo_pwm_sequencer: RTL

Parametrised multi-channel servo PWM generator with manual position control, snapshot recording and looped playback. It generalises the fixed two-axis debounce/move/store/PWM path to CH channels, with configurable resolution and depth, saturating limits, glitch-free duty updates and timed playback of a recorded position sequence. It sits after the button debouncers and drives the servo pulse pins directly.

---
 rtl/servo_pwm_sequencer_if.sv | 27 ++
 rtl/servo_pwm_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_sequencer_if.sv
// rtl/servo_pwm_sequencer_if.sv - control and status bundle for the servo PWM sequencer
interface servo_pwm_sequencer_if #(
    parameter int CH    = 2,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [CH-1:0] Inc;
    logic [CH-1:0] Dec;
    logic          Rec;
    logic          Clr;
    logic          Store_Sw;
    logic [CH-1:0] Pulse;
    logic [AW:0]   Rec_Count;
    logic          Full;
    logic [AW-1:0] Play_Idx;

    modport master (
        output Inc, Dec, Rec, Clr, Store_Sw,
        input  Pulse, Rec_Count, Full, Play_Idx
    );

    modport slave (
        input  Inc, Dec, Rec, Clr, Store_Sw,
        output Pulse, Rec_Count, Full, Play_Idx
    );
endinterface

// File: rtl/servo_pwm_sequencer.sv
// rtl/servo_pwm_sequencer.sv - multi-channel servo PWM with record/playback (optional SERVO_SOFT_RAMP_EN slew)
module servo_pwm_sequencer #(
    parameter int CH    = 2,
    parameter int CW    = 6,
    parameter int STEP  = 1,
    parameter int DMIN  = 0,
    parameter int DMAX  = 63,
    parameter int DEPTH = 16,
    parameter int DWELL = 64
) (
    input  logic                   sysclk,
    input  logic                   Reset_Sw,
    servo_pwm_sequencer_if.slave   bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW:0]    STEP_X     = (CW+1)'(STEP);
    localparam logic [CW:0]    DMIN_X     = (CW+1)'(DMIN);
    localparam logic [CW:0]    DMAX_X     = (CW+1)'(DMAX);
    localparam logic [CW-1:0]  MID        = CW'((DMIN + DMAX) / 2);
    localparam logic [AW:0]    DEPTH_X    = (AW+1)'(DEPTH);
    localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);

    // Registered state
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  pos_q [CH];
    logic [CW-1:0]  pos_d [CH];
    logic [CW-1:0]  active_q [CH];
    logic [CW-1:0]  active_d [CH];
    logic [CH-1:0]  pulse_q, pulse_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW:0]    rec_count_q, rec_count_d;
    logic [AW-1:0]  play_idx_q, play_idx_d;
    logic [DWW-1:0] dwell_q, dwell_d;
    logic           store_q, store_d;

    // Snapshot memory, one word holds all channel positions
    logic [CH*CW-1:0] snap_mem [DEPTH];
    logic             mem_we;
    logic [CH*CW-1:0] mem_wdata;
    logic [CH*CW-1:0] mem_rdata;

    logic             period_end;
    logic             full;
    logic             store_rise;
    logic [CW-1:0]    target [CH];

    assign period_end = (cnt_q == '1);
    assign full       = (rec_count_q == DEPTH_X);
    assign store_rise = bus.Store_Sw & ~store_q;

    // Free-running period counter and registered pulse compare
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        pulse_d = '0;
        for (int i = 0; i < CH; i++) begin
            pulse_d[i] = (cnt_q < active_q[i]);
        end
    end

    // Manual position stepping with saturation at the clamps
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            logic [CW:0] up;
            logic [CW:0] dn;
            pos_d[i] = pos_q[i];
            up = {1'b0, pos_q[i]} + STEP_X;
            dn = {1'b0, pos_q[i]} - STEP_X;
            if (!bus.Store_Sw && bus.Inc[i] && !bus.Dec[i]) begin
                pos_d[i] = (up > DMAX_X) ? DMAX_X[CW-1:0] : up[CW-1:0];
            end else if (!bus.Store_Sw && bus.Dec[i] && !bus.Inc[i]) begin
                if (({1'b0, pos_q[i]} < STEP_X) || (dn < DMIN_X)) begin
                    pos_d[i] = DMIN_X[CW-1:0];
                end else begin
                    pos_d[i] = dn[CW-1:0];
                end
            end
        end
    end

    // Snapshot recording; clear beats a simultaneous record
    always_comb begin
        rec_count_d = rec_count_q;
        wptr_d      = wptr_q;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        for (int i = 0; i < CH; i++) begin
            mem_wdata[i*CW +: CW] = pos_d[i];
        end
        if (!bus.Store_Sw) begin
            if (bus.Clr) begin
                rec_count_d = '0;
                wptr_d      = '0;
            end else if (bus.Rec && !full) begin
                mem_we      = 1'b1;
                wptr_d      = wptr_q + 1'b1;
                rec_count_d = rec_count_q + 1'b1;
            end
        end
    end

    // Playback sequencing: dwell counts period ends, index wraps at the record count
    always_comb begin
        store_d    = bus.Store_Sw;
        play_idx_d = play_idx_q;
        dwell_d    = dwell_q;
        if (store_rise) begin
            play_idx_d = '0;
            dwell_d    = '0;
        end else if (bus.Store_Sw && period_end) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                if (rec_count_q != '0) begin
                    if (((AW+1)'(play_idx_q) + 1'b1) == rec_count_q) begin
                        play_idx_d = '0;
                    end else begin
                        play_idx_d = play_idx_q + 1'b1;
                    end
                end
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    // Target selection; the next index is used so duty and Play_Idx change together
    always_comb begin
        mem_rdata = snap_mem[play_idx_d];
        for (int i = 0; i < CH; i++) begin
            if (bus.Store_Sw && (rec_count_q != '0)) begin
                target[i] = mem_rdata[i*CW +: CW];
            end else begin
                target[i] = pos_q[i];
            end
        end
    end

    // Active duty only changes at the period boundary so no period is truncated
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            logic [CW:0] up;
            logic [CW:0] gap;
            active_d[i] = active_q[i];
            up  = {1'b0, active_q[i]} + STEP_X;
            gap = {1'b0, active_q[i]} - {1'b0, target[i]};
            if (period_end) begin
`ifdef SERVO_SOFT_RAMP_EN
                if (target[i] > active_q[i]) begin
                    active_d[i] = (up >= {1'b0, target[i]}) ? target[i] : up[CW-1:0];
                end else if (target[i] < active_q[i]) begin
                    active_d[i] = (gap <= STEP_X) ? target[i] : (active_q[i] - STEP_X[CW-1:0]);
                end
`else
                active_d[i] = target[i];
`endif
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge sysclk or negedge Reset_Sw) begin
        if (!Reset_Sw) begin
            cnt_q       <= '0;
            pulse_q     <= '0;
            wptr_q      <= '0;
            rec_count_q <= '0;
            play_idx_q  <= '0;
            dwell_q     <= '0;
            store_q     <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                pos_q[i]    <= MID;
                active_q[i] <= MID;
            end
        end else begin
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            wptr_q      <= wptr_d;
            rec_count_q <= rec_count_d;
            play_idx_q  <= play_idx_d;
            dwell_q     <= dwell_d;
            store_q     <= store_d;
            for (int i = 0; i < CH; i++) begin
                pos_q[i]    <= pos_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    // Snapshot storage has no reset; it is never read while the count is zero
    always_ff @(posedge sysclk) begin
        if (mem_we) begin
            snap_mem[wptr_q] <= mem_wdata;
        end
    end

    assign bus.Pulse     = pulse_q;
    assign bus.Rec_Count = rec_count_q;
    assign bus.Full      = full;
    assign bus.Play_Idx  = play_idx_q;
endmodule
